// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states and oversampling constants.
// Used by both the receive and transmit engines.
package uart_pkg;

   localparam int unsigned OVERSAMPLE = 16;
   localparam int unsigned DEF_DVSR_W = 14;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversampling tick generator: one-clk tick every dvsr+1 clocks.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int unsigned DVSR_W = DEF_DVSR_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DVSR_W-1:0] dvsr,
   output logic              tick
);

   logic [DVSR_W-1:0] cnt_q, cnt_d;

   // >= lets a shrinking divisor recover within one period instead of wrapping
   always_comb begin
      tick  = (cnt_q >= dvsr);
      cnt_d = tick ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 serial receive engine: rx synchroniser, 16x oversampled deserialiser,
// one-cycle write strobe into the rx FIFO with frame-error and overrun flags.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int unsigned DBIT    = 8,
   parameter int unsigned SB_TICK = OVERSAMPLE,
   parameter int unsigned DVSR_W  = DEF_DVSR_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DVSR_W-1:0] dvsr,
   input  logic              rx,
   input  logic              rx_full,
   output logic [DBIT-1:0]   dout,
   output logic              rx_done_tick,
   output logic              frame_err,
   output logic              overrun,
   output logic              busy
);

   localparam int unsigned S_W = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : $clog2(OVERSAMPLE);
   localparam int unsigned N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

   logic            tick;
   logic            rx_meta_q, rx_s;
   rx_state_t       state_q, state_d;
   logic [S_W-1:0]  s_q, s_d;
   logic [N_W-1:0]  n_q, n_d;
   logic [DBIT-1:0] b_q, b_d;
   logic [DBIT-1:0] dout_q, dout_d;
   logic            ferr_q, ferr_d;
   logic            done_q, done_d;
   logic            ovr_q, ovr_d;

   uart_baud_gen #(
      .DVSR_W (DVSR_W)
   ) u_baud_gen (
      .clk     (clk),
      .reset_n (reset_n),
      .dvsr    (dvsr),
      .tick    (tick)
   );

   // Flops reset high so the line reads idle straight out of reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta_q <= 1'b1;
         rx_s      <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s      <= rx_meta_q;
      end
   end

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      b_d     = b_q;
      dout_d  = dout_q;
      ferr_d  = ferr_q;
      done_d  = 1'b0;
      ovr_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               s_d     = '0;
            end
         end
         START: begin
            if (tick) begin
               if (s_q == S_W'(OVERSAMPLE / 2 - 1)) begin
                  // Still low at mid start bit: real frame, otherwise a glitch
                  if (!rx_s) begin
                     state_d = DATA;
                     s_d     = '0;
                     n_d     = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (s_q == S_W'(OVERSAMPLE - 1)) begin
                  b_d = {rx_s, b_q[DBIT-1:1]};
                  s_d = '0;
                  if (n_q == N_W'(DBIT - 1)) begin
                     state_d = STOP;
                  end else begin
                     n_d = n_q + 1'b1;
                  end
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (s_q == S_W'(SB_TICK - 1)) begin
                  dout_d  = b_q;
                  ferr_d  = ~rx_s;
                  done_d  = 1'b1;
                  ovr_d   = rx_full;
                  state_d = IDLE;
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Strobe and flags are registered alongside dout so they are valid together
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         s_q     <= '0;
         n_q     <= '0;
         b_q     <= '0;
         dout_q  <= '0;
         ferr_q  <= 1'b0;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         b_q     <= b_d;
         dout_q  <= dout_d;
         ferr_q  <= ferr_d;
         done_q  <= done_d;
         ovr_q   <= ovr_d;
      end
   end

   assign dout         = dout_q;
   assign frame_err    = ferr_q;
   assign rx_done_tick = done_q;
   assign overrun      = ovr_q;
   assign busy         = (state_q != IDLE);

endmodule
